// File: rtl/gauss_rng_feeder.sv
// Feeds mkgauss two-beat random words from two xorshift64 generators and streams the captured samples out.
// Optional feature macro: SMP_SUM_EN adds sum_out, a signed running sum of accepted samples.
module gauss_rng_feeder #(
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 2000,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             seed_we,
    input  logic [63:0]      seed_a,
    input  logic [63:0]      seed_b,
    output logic             r1_valid,
    output logic             r2_valid,
    output logic [63:0]      r1,
    output logic [63:0]      r2,
    input  logic             val_valid,
    input  logic [31:0]      val,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [31:0]      smp_data,
    output logic             busy,
    output logic             done,
`ifdef SMP_SUM_EN
    output logic [47:0]      sum_out,
`endif
    output logic             err_timeout
);

    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BEAT_A = 4'd1,
        ST_GAP_A  = 4'd2,
        ST_BEAT_B = 4'd3,
        ST_WAIT   = 4'd4,
        ST_HOLD   = 4'd5,
        ST_PUSH   = 4'd6,
        ST_COOL   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    function automatic logic [63:0] xs64_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // An all-zero state would lock xorshift at zero forever
    function automatic logic [63:0] seed_fix(input logic [63:0] s);
        return (s == 64'd0) ? GOLDEN : s;
    endfunction

    state_t           state_r;
    logic [63:0]      gen_a_r;
    logic [63:0]      gen_b_r;
    logic [63:0]      gen_a_cur_s;
    logic [63:0]      gen_b_cur_s;
    logic             r_valid_r;
    logic [63:0]      r1_r;
    logic [63:0]      r2_r;
    logic             smp_valid_r;
    logic [31:0]      smp_data_r;
    logic             busy_r;
    logic             done_r;
    logic             err_timeout_r;
    logic [CNT_W-1:0] n_lat_r;
    logic [CNT_W-1:0] smp_cnt_r;
    logic [TW-1:0]    wait_cnt_r;
    logic [GW-1:0]    cool_cnt_r;
`ifdef SMP_SUM_EN
    logic [47:0]      sum_r;
`endif

    // Seed load takes effect in the same cycle so a simultaneous start uses the new seed
    always_comb begin
        gen_a_cur_s = gen_a_r;
        gen_b_cur_s = gen_b_r;
        if ((state_r == ST_IDLE) && seed_we) begin
            gen_a_cur_s = seed_fix(seed_a);
            gen_b_cur_s = seed_fix(seed_b);
        end else begin
            gen_a_cur_s = gen_a_r;
            gen_b_cur_s = gen_b_r;
        end
    end

    // Main sequencer: beat issue, result capture, sample push and run bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            gen_a_r       <= GOLDEN;
            gen_b_r       <= GOLDEN;
            r_valid_r     <= 1'b0;
            r1_r          <= 64'd0;
            r2_r          <= 64'd0;
            smp_valid_r   <= 1'b0;
            smp_data_r    <= 32'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            n_lat_r       <= {CNT_W{1'b0}};
            smp_cnt_r     <= {CNT_W{1'b0}};
            wait_cnt_r    <= {TW{1'b0}};
            cool_cnt_r    <= {GW{1'b0}};
`ifdef SMP_SUM_EN
            sum_r         <= 48'd0;
`endif
        end else begin
            gen_a_r   <= gen_a_cur_s;
            gen_b_r   <= gen_b_cur_s;
            r_valid_r <= 1'b0;
            r1_r      <= 64'd0;
            r2_r      <= 64'd0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        n_lat_r       <= n_samples;
                        smp_cnt_r     <= {CNT_W{1'b0}};
                        err_timeout_r <= 1'b0;
`ifdef SMP_SUM_EN
                        sum_r         <= 48'd0;
`endif
                        if (n_samples == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_BEAT_A;
                            busy_r    <= 1'b1;
                            r_valid_r <= 1'b1;
                            r1_r      <= gen_a_cur_s;
                            r2_r      <= gen_b_cur_s;
                            gen_a_r   <= xs64_step(gen_a_cur_s);
                            gen_b_r   <= xs64_step(gen_b_cur_s);
                        end
                    end
                end
                ST_BEAT_A: state_r <= ST_GAP_A;
                ST_GAP_A: begin
                    state_r   <= ST_BEAT_B;
                    r_valid_r <= 1'b1;
                    r1_r      <= gen_a_cur_s;
                    r2_r      <= gen_b_cur_s;
                    gen_a_r   <= xs64_step(gen_a_cur_s);
                    gen_b_r   <= xs64_step(gen_b_cur_s);
                end
                ST_BEAT_B: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    if (val_valid) begin
                        smp_data_r <= val;
                        state_r    <= ST_HOLD;
                    end else if (wait_cnt_r == TW'(TIMEOUT - 1)) begin
                        err_timeout_r <= 1'b1;
                        state_r       <= ST_DONE;
                        done_r        <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                // Only the first result cycle is captured; a held val_valid just delays the push
                ST_HOLD: begin
                    if (!val_valid) begin
                        state_r     <= ST_PUSH;
                        smp_valid_r <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (smp_ready) begin
                        smp_valid_r <= 1'b0;
                        smp_cnt_r   <= smp_cnt_r + CNT_W'(1);
                        cool_cnt_r  <= {GW{1'b0}};
                        state_r     <= ST_COOL;
`ifdef SMP_SUM_EN
                        sum_r       <= sum_r + {{16{smp_data_r[31]}}, smp_data_r};
`endif
                    end
                end
                ST_COOL: begin
                    if (cool_cnt_r == GW'(GAP - 1)) begin
                        if (smp_cnt_r != n_lat_r) begin
                            state_r   <= ST_BEAT_A;
                            r_valid_r <= 1'b1;
                            r1_r      <= gen_a_cur_s;
                            r2_r      <= gen_b_cur_s;
                            gen_a_r   <= xs64_step(gen_a_cur_s);
                            gen_b_r   <= xs64_step(gen_b_cur_s);
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cool_cnt_r <= cool_cnt_r + GW'(1);
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    smp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign r1_valid    = r_valid_r;
    assign r2_valid    = r_valid_r;
    assign r1          = r1_r;
    assign r2          = r2_r;
    assign smp_valid   = smp_valid_r;
    assign smp_data    = smp_data_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_timeout_r;
`ifdef SMP_SUM_EN
    assign sum_out     = sum_r;
`endif

endmodule
